// File: rtl/fir_xifu_pkg.sv
// Shared types and encodings for the FIR XIFU: operation enum, custom-0
// opcode / funct3 values and the control part of an ID-queue entry.
package fir_xifu_pkg;

   typedef enum logic [1:0] {
      OP_LDTAP = 2'd0,
      OP_LDSAM = 2'd1,
      OP_STSAM = 2'd2,
      OP_MAC   = 2'd3
   } fir_xifu_op_e;

   localparam logic [6:0] OPCODE_FIR   = 7'b0001011;
   localparam logic [2:0] FUNCT3_LDTAP = 3'b000;
   localparam logic [2:0] FUNCT3_LDSAM = 3'b001;
   localparam logic [2:0] FUNCT3_STSAM = 3'b010;
   localparam logic [2:0] FUNCT3_MAC   = 3'b011;

   // Register index field as it appears in the instruction word (instr[11:7]).
   localparam int IDX_FIELD_W = 5;

   // Parameter-independent control fields of a queue entry; the id and the
   // operand payload are sized by the queue's own parameters and stored
   // alongside in separate arrays.
   typedef struct packed {
      logic                   valid;
      logic                   committed;
      logic                   killed;
      fir_xifu_op_e           op;
      logic [IDX_FIELD_W-1:0] idx;
   } fir_xifu_id_entry_t;

endpackage

// File: rtl/fir_xifu_decoder.sv
// Combinational decode of an X-interface instruction word into the FIR
// operation, its register index, which operands it needs and whether it
// writes an integer rd.
import fir_xifu_pkg::*;

module fir_xifu_decoder #(
   parameter int NB_REGS    = 4,
   parameter bit ENABLE_MAC = 1'b1
) (
   input  logic [31:0]            i_instr,
   output logic                   o_accept,
   output fir_xifu_op_e           o_op,
   output logic [IDX_FIELD_W-1:0] o_idx,
   output logic [1:0]             o_rs_needed,
   output logic                   o_writeback
);

   localparam logic [IDX_FIELD_W:0] NB_LIM = (IDX_FIELD_W+1)'(NB_REGS);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic       w_idx_ok;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];
   assign o_idx    = i_instr[11:7];
   assign w_idx_ok = ({1'b0, o_idx} < NB_LIM);

   // Map funct3 to operation and operand needs; anything unknown is rejected.
   always_comb begin
      o_accept    = 1'b0;
      o_op        = OP_LDTAP;
      o_rs_needed = 2'b00;
      o_writeback = 1'b0;
      if (w_opcode == OPCODE_FIR && w_idx_ok) begin
         case (w_funct3)
            FUNCT3_LDTAP: begin
               o_accept    = 1'b1;
               o_op        = OP_LDTAP;
               o_rs_needed = 2'b01;
            end
            FUNCT3_LDSAM: begin
               o_accept    = 1'b1;
               o_op        = OP_LDSAM;
               o_rs_needed = 2'b01;
            end
            FUNCT3_STSAM: begin
               o_accept    = 1'b1;
               o_op        = OP_STSAM;
               o_writeback = 1'b1;
            end
            FUNCT3_MAC: begin
               if (ENABLE_MAC) begin
                  o_accept    = 1'b1;
                  o_op        = OP_MAC;
                  o_rs_needed = 2'b11;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fir_xifu_id_queue.sv
// ID stage of the FIR XIFU: accepts decoded instructions from the XIF issue
// channel into an in-order queue, records commit/kill per entry from the
// commit channel and hands committed, non-killed heads to EX.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. The issue side additionally needs issue_accept_o high to
// push; a rejected transfer completes but stores nothing. id2ex_* data is
// held stable while id2ex_valid_o is high and id2ex_ready_i is low.
import fir_xifu_pkg::*;

module fir_xifu_id_queue #(
   parameter int DEPTH      = 4,
   parameter int NB_REGS    = 4,
   parameter int ID_WIDTH   = 4,
   parameter int XLEN       = 32,
   parameter bit ENABLE_MAC = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       issue_valid_i,
   output logic                       issue_ready_o,
   input  logic [31:0]                issue_instr_i,
   input  logic [ID_WIDTH-1:0]        issue_id_i,
   input  logic [2*XLEN-1:0]          issue_rs_i,
   input  logic [1:0]                 issue_rs_valid_i,
   output logic                       issue_accept_o,
   output logic                       issue_writeback_o,
   input  logic                       commit_valid_i,
   input  logic [ID_WIDTH-1:0]        commit_id_i,
   input  logic                       commit_kill_i,
   output logic                       id2ex_valid_o,
   input  logic                       id2ex_ready_i,
   output logic [1:0]                 id2ex_op_o,
   output logic [ID_WIDTH-1:0]        id2ex_id_o,
   output logic [$clog2(NB_REGS)-1:0] id2ex_idx_o,
   output logic [XLEN-1:0]            id2ex_rs1_o,
   output logic [XLEN-1:0]            id2ex_rs2_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = $clog2(NB_REGS);

   fir_xifu_id_entry_t     r_ctl [DEPTH];
   logic [ID_WIDTH-1:0]    r_id  [DEPTH];
   logic [XLEN-1:0]        r_rs1 [DEPTH];
   logic [XLEN-1:0]        r_rs2 [DEPTH];
   logic [PTR_W-1:0]       r_wptr;
   logic [PTR_W-1:0]       r_rptr;
   logic [CNT_W-1:0]       r_cnt;

   logic                   w_accept;
   fir_xifu_op_e           w_op;
   logic [IDX_FIELD_W-1:0] w_idx;
   logic [1:0]             w_rs_needed;
   logic                   w_writeback;
   logic                   w_full;
   logic                   w_rs_ok;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_drop;
   logic                   w_commit_new;
   fir_xifu_id_entry_t     w_head;
   fir_xifu_id_entry_t     w_new;

   fir_xifu_decoder #(
      .NB_REGS    (NB_REGS),
      .ENABLE_MAC (ENABLE_MAC)
   ) u_decoder (
      .i_instr     (issue_instr_i),
      .o_accept    (w_accept),
      .o_op        (w_op),
      .o_idx       (w_idx),
      .o_rs_needed (w_rs_needed),
      .o_writeback (w_writeback)
   );

   // No push-through: a full queue refuses issue even while it pops.
   assign w_full            = (r_cnt == CNT_W'(DEPTH));
   assign w_rs_ok           = ((issue_rs_valid_i & w_rs_needed) == w_rs_needed);
   assign issue_ready_o     = !w_full && (!w_accept || w_rs_ok);
   assign issue_accept_o    = w_accept;
   assign issue_writeback_o = w_writeback;
   assign w_push            = issue_valid_i && issue_ready_o && w_accept;

   // A commit naming the id being issued lands on the entry being written.
   assign w_commit_new = commit_valid_i && (commit_id_i == issue_id_i);

   // Head release: committed and alive goes to EX, committed and killed is
   // silently dropped, uncommitted blocks.
   assign w_head        = r_ctl[r_rptr];
   assign id2ex_valid_o = w_head.valid && w_head.committed && !w_head.killed;
   assign w_drop        = w_head.valid && w_head.committed && w_head.killed;
   assign w_pop         = (id2ex_valid_o && id2ex_ready_i) || w_drop;

   assign id2ex_op_o  = id2ex_valid_o ? w_head.op             : 2'd0;
   assign id2ex_idx_o = id2ex_valid_o ? w_head.idx[IDX_W-1:0] : '0;
   assign id2ex_id_o  = id2ex_valid_o ? r_id[r_rptr]          : '0;
   assign id2ex_rs1_o = id2ex_valid_o ? r_rs1[r_rptr]         : '0;
   assign id2ex_rs2_o = id2ex_valid_o ? r_rs2[r_rptr]         : '0;

   // Build the control word for a newly pushed entry.
   always_comb begin
      w_new           = '0;
      w_new.valid     = 1'b1;
      w_new.committed = w_commit_new;
      w_new.killed    = w_commit_new && commit_kill_i;
      w_new.op        = w_op;
      w_new.idx       = w_idx;
   end

   // Queue storage, commit search over all live entries, pointers and count.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_ctl[i] <= '0;
            r_id[i]  <= '0;
            r_rs1[i] <= '0;
            r_rs2[i] <= '0;
         end
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid_i && r_ctl[i].valid && (r_id[i] == commit_id_i)) begin
               r_ctl[i].committed <= 1'b1;
               r_ctl[i].killed    <= commit_kill_i;
            end
         end
         if (w_push) begin
            r_ctl[r_wptr] <= w_new;
            r_id[r_wptr]  <= issue_id_i;
            r_rs1[r_wptr] <= issue_rs_i[XLEN-1:0];
            r_rs2[r_wptr] <= issue_rs_i[2*XLEN-1:XLEN];
            r_wptr        <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_ctl[r_rptr].valid <= 1'b0;
            r_rptr              <= r_rptr + PTR_W'(1);
         end
         r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

endmodule

// File: tb/tb_fir_xifu_id_queue.sv
// Self-checking bench for fir_xifu_id_queue: directed scenarios followed by
// randomized traffic, compared against an in-order queue model of issue,
// commit and kill. A second instance with MAC disabled checks decode only.
module tb_fir_xifu_id_queue;

   localparam int DEPTH   = 4;
   localparam int NB_REGS = 4;
   localparam int IDW     = 4;
   localparam int XLEN    = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic            issue_valid;
   logic [31:0]     instr;
   logic [IDW-1:0]  iid;
   logic [63:0]     rs;
   logic [1:0]      rsv;
   logic            cv;
   logic [IDW-1:0]  cid;
   logic            ck;
   logic            rdy;

   logic            issue_ready, accept, wb, o_valid;
   logic [1:0]      o_op;
   logic [IDW-1:0]  o_id;
   logic [1:0]      o_idx;
   logic [31:0]     o_rs1, o_rs2;

   logic            nm_ready, nm_accept, nm_wb, nm_valid;
   logic [1:0]      nm_op;
   logic [IDW-1:0]  nm_id;
   logic [1:0]      nm_idx;
   logic [31:0]     nm_rs1, nm_rs2;

   fir_xifu_id_queue #(.DEPTH(DEPTH), .NB_REGS(NB_REGS), .ID_WIDTH(IDW),
                       .XLEN(XLEN), .ENABLE_MAC(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
      .issue_instr_i(instr), .issue_id_i(iid), .issue_rs_i(rs),
      .issue_rs_valid_i(rsv), .issue_accept_o(accept), .issue_writeback_o(wb),
      .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
      .id2ex_valid_o(o_valid), .id2ex_ready_i(rdy), .id2ex_op_o(o_op),
      .id2ex_id_o(o_id), .id2ex_idx_o(o_idx), .id2ex_rs1_o(o_rs1),
      .id2ex_rs2_o(o_rs2)
   );

   fir_xifu_id_queue #(.DEPTH(DEPTH), .NB_REGS(NB_REGS), .ID_WIDTH(IDW),
                       .XLEN(XLEN), .ENABLE_MAC(1'b0)) dut_nomac (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(issue_valid), .issue_ready_o(nm_ready),
      .issue_instr_i(instr), .issue_id_i(iid), .issue_rs_i(rs),
      .issue_rs_valid_i(rsv), .issue_accept_o(nm_accept), .issue_writeback_o(nm_wb),
      .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
      .id2ex_valid_o(nm_valid), .id2ex_ready_i(rdy), .id2ex_op_o(nm_op),
      .id2ex_id_o(nm_id), .id2ex_idx_o(nm_idx), .id2ex_rs1_o(nm_rs1),
      .id2ex_rs2_o(nm_rs2)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [1:0]     op;
      logic [IDW-1:0] id;
      logic [1:0]     idx;
      logic [31:0]    rs1;
      logic [31:0]    rs2;
      bit             committed;
      bit             killed;
   } ment_t;

   typedef struct {
      logic [IDW-1:0] id;
      bit             older_done;
      int             age;
   } khold_t;

   ment_t       mq[$];        // issued, not yet resolved, in program order
   logic [71:0] exp_q[$];     // expected EX outputs {op,id,idx,rs1,rs2}
   khold_t      kill_hold[$]; // killed ids that may still sit in the DUT

   int n_vec = 0;
   int n_err = 0;

   // snapshots taken at the sampling edge of each tick
   logic        s_valid, s_issue_ready, s_accept, s_wb, s_nm_accept, s_nm_ready;
   logic [1:0]  s_op, s_idx;
   logic [3:0]  s_id;
   logic [31:0] s_rs1;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void ref_decode(input logic [31:0] ins, input bit mac_en,
                                      output bit acc, output logic [1:0] op,
                                      output logic [1:0] need, output bit wbk);
      acc = 0; op = 2'd0; need = 2'b00; wbk = 0;
      if (ins[6:0] == 7'b0001011 && int'(ins[11:7]) < NB_REGS) begin
         case (ins[14:12])
            3'd0: begin acc = 1; op = 2'd0; need = 2'b01; end
            3'd1: begin acc = 1; op = 2'd1; need = 2'b01; end
            3'd2: begin acc = 1; op = 2'd2; wbk = 1; end
            3'd3: if (mac_en) begin acc = 1; op = 2'd3; need = 2'b11; end
            default: ;
         endcase
      end
   endfunction

   function automatic logic [71:0] pack(input ment_t e);
      return {e.op, e.id, e.idx, e.rs1, e.rs2};
   endfunction

   function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] idx);
      logic [16:0] up;
      up = 17'($urandom_range(0, 131071));
      return {up, f3, idx, 7'b0001011};
   endfunction

   function automatic bit id_busy(input logic [IDW-1:0] id);
      logic [71:0] e;
      foreach (mq[i]) if (mq[i].id == id) return 1;
      foreach (exp_q[i]) begin
         e = exp_q[i];
         if (e[69:66] == id) return 1;
      end
      foreach (kill_hold[i]) if (kill_hold[i].id == id) return 1;
      return 0;
   endfunction

   // ---------------- driver ----------------
   // One clock cycle: inputs already set; sample and update the model at the
   // falling edge, then return just after the rising edge with issue/commit
   // cleared (id2ex ready and reset are sticky).
   task automatic tick();
      bit acc, wbk, nacc, nwbk;
      logic [1:0] op, need, nop, nneed;
      ment_t e;
      @(negedge clk);
      s_valid = o_valid; s_issue_ready = issue_ready; s_accept = accept; s_wb = wb;
      s_nm_accept = nm_accept; s_nm_ready = nm_ready;
      s_op = o_op; s_idx = o_idx; s_id = o_id; s_rs1 = o_rs1;
      if (!rst_n) begin
         mq.delete(); exp_q.delete(); kill_hold.delete();
      end else begin
         if (issue_valid) begin
            ref_decode(instr, 1'b1, acc, op, need, wbk);
            ref_decode(instr, 1'b0, nacc, nop, nneed, nwbk);
            chk("accept", 72'(accept), 72'(acc));
            chk("writeback", 72'(wb), 72'(wbk));
            chk("nomac_accept", 72'(nm_accept), 72'(nacc));
            if (acc && ((rsv & need) != need))
               chk("ready_needs_rs", 72'(issue_ready), 72'(0));
            if (issue_ready && acc) begin
               e.op = op; e.id = iid; e.idx = instr[8:7];
               e.rs1 = rs[31:0]; e.rs2 = rs[63:32];
               e.committed = 0; e.killed = 0;
               mq.push_back(e);
            end
         end
         if (cv)
            foreach (mq[i]) if (mq[i].id == cid) begin
               mq[i].committed = 1; mq[i].killed = ck;
            end
         foreach (kill_hold[i]) begin
            if (exp_q.size() == 0) kill_hold[i].older_done = 1;
            if (kill_hold[i].older_done) kill_hold[i].age++;
         end
         while (kill_hold.size() > 0 && kill_hold[0].age > DEPTH + 1) void'(kill_hold.pop_front());
         while (mq.size() > 0 && mq[0].committed) begin
            e = mq.pop_front();
            if (e.killed) kill_hold.push_back('{e.id, 0, 0});
            else exp_q.push_back(pack(e));
         end
      end
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
      cv          = 1'b0;
      ck          = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic        hold_v = 1'b0;
   logic [71:0] hold_d;

   always @(negedge clk) begin
      logic [71:0] got, want;
      got = {o_op, o_id, o_idx, o_rs1, o_rs2};
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("hold_valid", 72'(o_valid), 72'(1));
            chk("hold_stable", got, hold_d);
         end
         if (o_valid && rdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", got, 72'(0));
               if (got == 72'(0)) begin
                  n_err++;
                  $display("FAIL unexpected_output: zero entry emitted with nothing expected");
               end
            end else begin
               want = exp_q.pop_front();
               chk("ex_output", got, want);
            end
         end
         hold_v = o_valid && !rdy;
         hold_d = got;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [IDW-1:0] pick;
      bit found;
      int r;
      int unc[$];
      rst_n = 1'b0; issue_valid = 1'b0; instr = '0; iid = '0; rs = '0; rsv = '0;
      cv = 1'b0; cid = '0; ck = 1'b0; rdy = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("reset_valid", 72'(s_valid), 72'(0));
      chk("reset_ready", 72'(s_issue_ready), 72'(1));
      chk("reset_id", 72'(s_id), 72'(0));
      chk("reset_rs1", 72'(s_rs1), 72'(0));

      // T1: LDTAP issue, commit next cycle, output two cycles after issue
      instr = mk(3'd0, 5'd2); iid = 4'd3; rs = {32'h0, 32'h1234}; rsv = 2'b01;
      issue_valid = 1'b1; rdy = 1'b0;
      tick();
      chk("t1_ready", 72'(s_issue_ready), 72'(1));
      cv = 1'b1; cid = 4'd3;
      tick();
      chk("t1_latency", 72'(s_valid), 72'(0));
      tick();
      chk("t1_valid", 72'(s_valid), 72'(1));
      chk("t1_op", 72'(s_op), 72'(0));
      chk("t1_idx", 72'(s_idx), 72'(2));
      chk("t1_rs1", 72'(s_rs1), 72'(32'h1234));
      chk("t1_id", 72'(s_id), 72'(3));
      rdy = 1'b1;
      tick();
      tick();
      chk("t1_empty", 72'(s_valid), 72'(0));

      // T2: MAC without MAC support, illegal index, missing rs2
      instr = mk(3'd3, 5'd1); iid = 4'd5; rsv = 2'b11; issue_valid = 1'b1;
      tick();
      chk("t2_nomac_accept", 72'(s_nm_accept), 72'(0));
      chk("t2_nomac_ready", 72'(s_nm_ready), 72'(1));
      chk("t2_mac_accept", 72'(s_accept), 72'(1));
      cv = 1'b1; cid = 4'd5; ck = 1'b1;
      tick();
      tick();
      instr = mk(3'd1, 5'd5); iid = 4'd6; rsv = 2'b01; issue_valid = 1'b1;
      tick();
      chk("t2_idx_accept", 72'(s_accept), 72'(0));
      chk("t2_idx_ready", 72'(s_issue_ready), 72'(1));
      cv = 1'b1; cid = 4'd6;
      tick();
      tick();
      chk("t2_no_push", 72'(s_valid), 72'(0));
      instr = mk(3'd3, 5'd0); iid = 4'd9; rsv = 2'b01; issue_valid = 1'b1;
      tick();
      chk("t2_rs2_missing", 72'(s_issue_ready), 72'(0));
      chk("t2_nomac_rs2_ready", 72'(s_nm_ready), 72'(1));

      // T3: fill, full blocks issue even while popping, drain in order
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         instr = mk(3'd1, 5'(i)); iid = 4'(i); rsv = 2'b01;
         rs = {$urandom, $urandom}; issue_valid = 1'b1;
         tick();
         chk("t3_fill_ready", 72'(s_issue_ready), 72'(1));
      end
      instr = mk(3'd0, 5'd0); iid = 4'd4; issue_valid = 1'b1;
      tick();
      chk("t3_full", 72'(s_issue_ready), 72'(0));
      rdy = 1'b1; cv = 1'b1; cid = 4'd0;
      tick();
      issue_valid = 1'b1; cv = 1'b1; cid = 4'd1;
      tick();
      chk("t3_full_pop_ready", 72'(s_issue_ready), 72'(0));
      chk("t3_full_pop_valid", 72'(s_valid), 72'(1));
      chk("t3_head0", 72'(s_id), 72'(0));
      cv = 1'b1; cid = 4'd2; tick();
      cv = 1'b1; cid = 4'd3; tick();
      tick(); tick();
      issue_valid = 1'b1;
      tick();
      chk("t3_ready_back", 72'(s_issue_ready), 72'(1));
      cv = 1'b1; cid = 4'd4; ck = 1'b1;
      tick(); tick();

      // T4: kill the middle entry, one idle drop cycle
      for (int i = 1; i <= 3; i++) begin
         instr = mk(3'd1, 5'd1); iid = 4'(i); rsv = 2'b01; rs = {$urandom, $urandom};
         issue_valid = 1'b1;
         tick();
      end
      cv = 1'b1; cid = 4'd1; tick();
      cv = 1'b1; cid = 4'd2; ck = 1'b1; tick();
      chk("t4_first", 72'(s_id), 72'(1));
      cv = 1'b1; cid = 4'd3; tick();
      chk("t4_drop", 72'(s_valid), 72'(0));
      tick();
      chk("t4_second_v", 72'(s_valid), 72'(1));
      chk("t4_second", 72'(s_id), 72'(3));
      tick();
      chk("t4_empty", 72'(s_valid), 72'(0));

      // T5: issue with same-cycle commit, back-pressure for three cycles
      instr = mk(3'd2, 5'd1); iid = 4'd7; rsv = 2'b00; rs = {$urandom, $urandom};
      issue_valid = 1'b1; cv = 1'b1; cid = 4'd7; rdy = 1'b0;
      tick();
      chk("t5_wb", 72'(s_wb), 72'(1));
      chk("t5_accept", 72'(s_accept), 72'(1));
      repeat (3) begin
         tick();
         chk("t5_held_v", 72'(s_valid), 72'(1));
         chk("t5_held_id", 72'(s_id), 72'(7));
      end
      rdy = 1'b1;
      tick();
      tick();
      chk("t5_single_pop", 72'(s_valid), 72'(0));

      // T6: reset with entries queued, two committed
      rdy = 1'b0;
      for (int i = 8; i <= 10; i++) begin
         instr = mk(3'd0, 5'd3); iid = 4'(i); rsv = 2'b01; rs = {$urandom, $urandom};
         issue_valid = 1'b1;
         tick();
      end
      cv = 1'b1; cid = 4'd8; tick();
      cv = 1'b1; cid = 4'd9; tick();
      tick();
      chk("t6_pre_valid", 72'(s_valid), 72'(1));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; rdy = 1'b1; instr = mk(3'd0, 5'd0); rsv = 2'b01;
      tick();
      chk("t6_valid", 72'(s_valid), 72'(0));
      chk("t6_ready", 72'(s_issue_ready), 72'(1));
      repeat (3) tick();
      chk("t6_no_stale", 72'(s_valid), 72'(0));

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         rdy = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) < 6) begin
            found = 0;
            for (int a = 0; a < 32 && !found; a++) begin
               pick = 4'($urandom_range(0, 15));
               if (!id_busy(pick)) found = 1;
            end
            if (found) begin
               instr = mk(($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                                     : 3'($urandom_range(0, 3)),
                          5'($urandom_range(0, 4)));
               if ($urandom_range(0, 19) == 0) instr[6:0] = 7'h33;
               iid = pick; rs = {$urandom, $urandom};
               rsv = ($urandom_range(0, 4) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
               issue_valid = 1'b1;
            end
         end
         r = $urandom_range(0, 9);
         unc.delete();
         foreach (mq[i]) if (!mq[i].committed) unc.push_back(i);
         if (r < 4 && unc.size() > 0) begin
            cv = 1'b1; cid = mq[unc[$urandom_range(0, unc.size() - 1)]].id;
            ck = ($urandom_range(0, 3) == 0);
         end else if (r == 4 && issue_valid) begin
            cv = 1'b1; cid = iid; ck = ($urandom_range(0, 3) == 0);
         end else if (r == 5) begin
            pick = 4'($urandom_range(0, 15));
            if (!id_busy(pick) && !(issue_valid && pick == iid)) begin
               cv = 1'b1; cid = pick; ck = $urandom_range(0, 1);
            end
         end
         tick();
      end

      // Drain: commit whatever remains, then let the queue empty
      rdy = 1'b1;
      for (int n = 0; n < 3 * DEPTH && mq.size() > 0; n++) begin
         cv = 1'b1; cid = mq[0].id; ck = 1'b0;
         tick();
      end
      repeat (16) tick();
      chk("drain_model_empty", 72'(mq.size()), 72'(0));
      chk("drain_all_emitted", 72'(exp_q.size()), 72'(0));
      chk("drain_valid_low", 72'(o_valid), 72'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fir_xifu_id_queue.md
Name: fir_xifu_id_queue

Overview:
- Parametrised next-generation ID stage of the FIR XIFU.
- Decodes instructions offered on the X-interface issue channel and accepts or rejects them.
- Buffers accepted instructions in an in-order queue of depth DEPTH, tracks per-entry commit/kill state from the commit channel, and releases only committed, non-killed entries to EX through a valid/ready handshake.
- Sits between the core's XIF issue/commit ports and fir_xifu_ex.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
NB_REGS, 4, number of tap/sample registers; index = instr[11:7], legal if < NB_REGS
ID_WIDTH, 4, XIF instruction-id width
XLEN, 32, operand width
ENABLE_MAC, 1, 1 = MAC funct3 accepted; 0 = MAC rejected

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
issue_valid_i  in  1  issue request valid
issue_ready_o  out  1  issue request ready
issue_instr_i  in  32  instruction word
issue_id_i  in  ID_WIDTH  instruction id
issue_rs_i  in  2*XLEN  {rs2,rs1} operand values
issue_rs_valid_i  in  2  operand valid flags
issue_accept_o  out  1  instruction accepted
issue_writeback_o  out  1  instruction writes an integer rd (STSAM only)
commit_valid_i  in  1  commit transaction valid
commit_id_i  in  ID_WIDTH  id being committed/killed
commit_kill_i  in  1  1 = kill, 0 = commit
id2ex_valid_o  out  1  head entry available to EX
id2ex_ready_i  in  1  EX consumes head
id2ex_op_o  out  2  fir_xifu_op_e of head
id2ex_id_o  out  ID_WIDTH  id of head
id2ex_idx_o  out  $clog2(NB_REGS)  register index of head
id2ex_rs1_o  out  XLEN  rs1 of head
id2ex_rs2_o  out  XLEN  rs2 of head

Behaviour:
- Clock is clk_i; reset is rst_ni, synchronous and active-low.
- Reset:
  - all entries invalid; read/write pointers and count = 0
  - id2ex_valid_o = 0; id2ex_* data = 0
  - reset mid-operation discards every queued entry, committed or not
- Decode is combinational.
  - Opcode 7'b0001011 (custom-0) is required.
  - funct3 decoding: 000 LDTAP (needs rs1), 001 LDSAM (needs rs1), 010 STSAM (needs none), 011 MAC (needs rs1, rs2; legal only if ENABLE_MAC).
  - Any other funct3, any other opcode, or idx >= NB_REGS -> reject.
- Issue handshake:
  - issue_ready_o = !full && (reject || all required rs_valid bits set).
  - issue_accept_o and issue_writeback_o are valid whenever issue_valid_i=1; both are 0 on reject.
  - Handshake (valid && ready && accept) pushes {op, id, idx, rs1, rs2, committed=0, killed=0} at the write pointer.
  - A rejected handshake pushes nothing.
- Commit:
  - On commit_valid_i, every valid entry whose id == commit_id_i gets committed=1, and killed=commit_kill_i.
  - An unmatched id is ignored; this covers rejected instructions.
  - Commit in the same cycle as the issue of the same id is applied to the entry being written.
- Head logic:
  - id2ex_valid_o = head valid && committed && !killed.
  - Pop on id2ex_valid_o && id2ex_ready_i.
  - A committed-and-killed head is dropped without output, one cycle per entry.
  - Uncommitted heads block.
- Latency: issue and commit at cycle N -> id2ex_valid_o at N+1 at the earliest.
- Full queue: issue_ready_o = 0 even if a pop happens that cycle (no push-through).
- Empty queue: id2ex_valid_o = 0.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Simultaneous push and pop when not full: count unchanged.
- id2ex_* data holds stable while id2ex_valid_o && !id2ex_ready_i.

Decomposition:
- fir_xifu_pkg holds:
  - fir_xifu_op_e (LDTAP=0, LDSAM=1, STSAM=2, MAC=3)
  - OPCODE_FIR and the FUNCT3_* constants
  - fir_xifu_id_entry_t, parametrised via a localparam-sized struct or a generic packed layout
- Sub-module fir_xifu_decoder: combinational instr -> {accept, op, idx, rs_needed, writeback}.
- Queue storage, pointers and commit search stay in fir_xifu_id_queue.

Test Plan:
- Issue LDTAP (funct3 000, idx 2, rs1=0x1234, rs_valid=01) id=3, then commit id=3 next cycle -> accept=1; id2ex_valid_o=1 two cycles after issue with op=LDTAP, idx=2, rs1=0x1234.
- Issue MAC with ENABLE_MAC=0, and LDSAM with idx=5 at NB_REGS=4 -> ready=1, accept=0, queue count remains 0.
- Issue ids 0..3 without commit, DEPTH=4 -> issue_ready_o=0 on the 5th; commit ids 0..3 with id2ex_ready_i=1 -> four outputs in order 0,1,2,3, then ready returns.
- Issue ids 1,2,3; kill id 2; commit 1 and 3 -> EX sees ids 1 then 3 only, with one idle drop cycle between them.
- Issue id 7 with commit id 7 in the same cycle, and hold id2ex_ready_i=0 for 3 cycles -> id2ex_valid_o stays 1 with stable data; one pop when ready=1.
- Assert rst_ni=0 for one cycle with 3 entries queued (2 committed) -> next cycle id2ex_valid_o=0, issue_ready_o=1, no stale entries emitted.
